// File: rtl/p_box_pipe.sv
// Pipelined MacGuffin 48-bit P-box with per-beat forward/inverse select.
// STAGES register slots (1..4), valid/ready on both sides, accepted-beat counter.
module p_box_pipe #(
  parameter int STAGES = 2,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [47:0]      data,
  input  logic             inverse,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [47:0]      permutation,
  output logic [CNT_W-1:0] beat_count
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("p_box_pipe: STAGES must be in 1..4");
  end

  // Entry i is the data index feeding output bit 47-i.
  localparam logic [5:0] P_SEL [48] = '{
    6'd45, 6'd42, 6'd25, 6'd22, 6'd4,  6'd2,
    6'd46, 6'd43, 6'd24, 6'd21, 6'd7,  6'd1,
    6'd44, 6'd41, 6'd23, 6'd18, 6'd15, 6'd0,
    6'd35, 6'd33, 6'd30, 6'd29, 6'd11, 6'd5,
    6'd47, 6'd37, 6'd28, 6'd17, 6'd9,  6'd3,
    6'd40, 6'd39, 6'd19, 6'd16, 6'd14, 6'd10,
    6'd38, 6'd32, 6'd26, 6'd20, 6'd13, 6'd8,
    6'd36, 6'd34, 6'd31, 6'd27, 6'd12, 6'd6
  };

  function automatic logic [47:0] p_fwd(input logic [47:0] d);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = d[P_SEL[i]];
    return r;
  endfunction

  function automatic logic [47:0] p_inv(input logic [47:0] d);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[P_SEL[i]] = d[47-i];
    return r;
  endfunction

  // Handshake: a beat moves across a boundary on a rising edge where the
  // sender's valid and the receiver's ready are both high in the same cycle.
  logic [STAGES-1:0] slot_valid;
  logic [47:0]       slot_data [STAGES];
  logic [STAGES-1:0] slot_ready;
  logic [47:0]       mapped;

  assign mapped = inverse ? p_inv(data) : p_fwd(data);

  // A slot can load if it, or any slot downstream of it, has room, or the
  // consumer is draining the last slot.
  always_comb begin
    logic acc;
    slot_ready = '0;
    acc = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc = acc | ~slot_valid[i];
      slot_ready[i] = acc;
    end
  end

  assign in_ready    = slot_ready[0];
  assign out_valid   = slot_valid[STAGES-1];
  assign permutation = slot_data[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
      for (int i = 0; i < STAGES; i++) slot_data[i] <= '0;
    end else begin
      if (slot_ready[0]) begin
        slot_valid[0] <= in_valid;
        if (in_valid) slot_data[0] <= mapped;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (slot_ready[i]) begin
          slot_valid[i] <= slot_valid[i-1];
          if (slot_valid[i-1]) slot_data[i] <= slot_data[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) beat_count <= '0;
    else if (in_valid && slot_ready[0]) beat_count <= beat_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_p_box_pipe.sv
// Scoreboard bench for p_box_pipe: sweeps, round trip, backpressure,
// throughput, mid-stream reset and counter wrap.
module tb_p_box_pipe;
  localparam int STAGES = 3;
  localparam int CNT_W  = 4;

  localparam int P_TAB [48] = '{
    45, 42, 25, 22, 4, 2,   46, 43, 24, 21, 7, 1,
    44, 41, 23, 18, 15, 0,  35, 33, 30, 29, 11, 5,
    47, 37, 28, 17, 9, 3,   40, 39, 19, 16, 14, 10,
    38, 32, 26, 20, 13, 8,  36, 34, 31, 27, 12, 6
  };

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [47:0]      data = '0;
  logic             inverse = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [47:0]      permutation;
  logic [CNT_W-1:0] beat_count;

  p_box_pipe #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .inverse(inverse),
    .out_valid(out_valid), .out_ready(out_ready),
    .permutation(permutation), .beat_count(beat_count)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- checking ----
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [47:0] m_fwd(input logic [47:0] w);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = w[P_TAB[i]];
    return r;
  endfunction

  function automatic logic [47:0] m_inv(input logic [47:0] w);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[P_TAB[i]] = w[47-i];
    return r;
  endfunction

  // ---- scoreboard / monitor (samples on the falling edge) ----
  logic [47:0]      exp_q[$];
  logic [47:0]      drv_exp = '0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             stalled = 1'b0;
  logic [47:0]      stall_data = '0;
  int last_acc_cyc = 0, last_del_cyc = 0;
  int tp_acc_first = -1, tp_del_first = -1, tp_del_last = -1, tp_del_n = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_cnt = '0;
      stalled = 1'b0;
    end else begin
      check("beat_count", 64'(beat_count), 64'(exp_cnt));
      if (stalled) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_hold", 64'(permutation), 64'(stall_data));
      end
      stalled    = out_valid && !out_ready;
      stall_data = permutation;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 64'(exp_q.size()), 64'd1);
        else check("data_out", 64'(permutation), 64'(exp_q.pop_front()));
        last_del_cyc = cyc;
        if (tp_del_first < 0) tp_del_first = cyc;
        tp_del_last = cyc;
        tp_del_n++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(drv_exp);
        exp_cnt = exp_cnt + 1'b1;
        last_acc_cyc = cyc;
        if (tp_acc_first < 0) tp_acc_first = cyc;
      end
    end
  end

  // ---- driver tasks (called at posedge + #1) ----
  task automatic send(input logic [47:0] d, input logic inv, input logic [47:0] e);
    int waited;
    waited   = 0;
    data     = d;
    inverse  = inv;
    drv_exp  = e;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 300) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [47:0] rand48();
    return {16'($urandom()), $urandom()};
  endfunction

  logic [47:0] w, f;
  logic        sent_done;

  initial begin
    // reset state
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_permutation", 64'(permutation), 64'd0);
    check("rst_beat_count", 64'(beat_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // first beat latency and spec examples
    out_ready = 1'b1;
    send(48'h1, 1'b0, 48'h0000_4000_0000);
    wait_drain();
    check("latency", 64'(last_del_cyc - last_acc_cyc), 64'(STAGES));
    send(48'h2000_0000_0000, 1'b0, 48'h8000_0000_0000);
    send(48'h8000_0000_0000, 1'b1, 48'h2000_0000_0000);
    send(48'h0000_0000_0001, 1'b1, 48'h0000_0000_0040);

    // single-bit sweeps, forward and complemented
    for (int j = 0; j < 48; j++) begin
      w = 48'h1 << j;
      send(w, 1'b0, m_fwd(w));
    end
    for (int j = 0; j < 48; j++) begin
      w = 48'h1 << j;
      send(~w, 1'b0, ~m_fwd(w));
    end
    wait_drain();

    // round trip with random stalls
    sent_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          w = rand48();
          f = m_fwd(w);
          send(w, 1'b0, f);
          send(f, 1'b1, w);
        end
        sent_done = 1'b1;
      end
      begin
        while (!sent_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // backpressure
    do_reset();
    out_ready = 1'b0;
    sent_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          w = rand48();
          send(w, k[0], k[0] ? m_inv(w) : m_fwd(w));
        end
        sent_done = 1'b1;
      end
      begin
        int budget;
        repeat (8) @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_count", 64'(beat_count), 64'd3);
        check("bp_queue", 64'(exp_q.size()), 64'(STAGES));
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        check("bp_ready_follows", 64'(in_ready), 64'd1);
        budget = 0;
        while (!(sent_done && exp_q.size() == 0) && budget < 2000) begin
          @(posedge clk); #1;
          out_ready = $urandom_range(0, 1) != 0;
          budget++;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    check("bp_final_count", 64'(beat_count), 64'd10);

    // throughput
    tp_acc_first = -1; tp_del_first = -1; tp_del_last = -1; tp_del_n = 0;
    for (int k = 0; k < 100; k++) begin
      w = rand48();
      send(w, 1'b0, m_fwd(w));
    end
    wait_drain();
    check("tp_first", 64'(tp_del_first - tp_acc_first), 64'(STAGES));
    check("tp_span", 64'(tp_del_last - tp_del_first), 64'd99);
    check("tp_count", 64'(tp_del_n), 64'd100);

    // mid-stream reset
    out_ready = 1'b0;
    send(rand48(), 1'b0, 48'h0);
    send(rand48(), 1'b1, 48'h0);
    rst = 1'b1;
    in_valid = 1'b1;
    data = rand48();
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_count", 64'(beat_count), 64'd0);
    check("mr_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    w = rand48();
    send(w, 1'b1, m_inv(w));
    wait_drain();
    check("mr_latency", 64'(last_del_cyc - last_acc_cyc), 64'(STAGES));
    repeat (4) @(posedge clk);
    #1;

    // counter wrap
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      w = rand48();
      send(w, 1'b0, m_fwd(w));
    end
    check("wrap_15", 64'(beat_count), 64'd15);
    w = rand48();
    send(w, 1'b0, m_fwd(w));
    check("wrap_16", 64'(beat_count), 64'd0);
    w = rand48();
    send(w, 1'b1, m_inv(w));
    check("wrap_17", 64'(beat_count), 64'd1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
